// File: rtl/tl_pkg.sv
// Shared TileLink-UL constants, field widths and the beat-count helper
// used by the SRAM responder.
package tl_pkg;

  localparam int TL_SRC_W  = 4;
  localparam int TL_ADDR_W = 32;
  localparam int TL_DATA_W = 64;
  localparam int TL_MASK_W = TL_DATA_W / 8;

  localparam logic [2:0] TL_A_PUT_FULL    = 3'd0;
  localparam logic [2:0] TL_A_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] TL_A_ARITHMETIC  = 3'd2;
  localparam logic [2:0] TL_A_LOGICAL     = 3'd3;
  localparam logic [2:0] TL_A_GET         = 3'd4;

  localparam logic [2:0] TL_D_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] TL_D_ACCESS_ACK_DATA = 3'd1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PUT_BURST = 2'd1,
    ST_ACK       = 2'd2,
    ST_GET_BURST = 2'd3
  } tl_resp_state_e;

  // Beats on an 8-byte bus; a size-7 request needs 16, hence 5 bits.
  function automatic logic [4:0] tl_beats(input logic [2:0] size);
    if (size <= 3'd3) return 5'd1;
    return 5'd1 << (size - 3'd3);
  endfunction

endpackage

// File: rtl/tl_sram_responder_mem.sv
// Scratch memory for the responder: byte-masked write port and a read
// port whose output register only updates when a read is issued.
module tl_sram_responder_mem
  import tl_pkg::*;
#(
  parameter int DEPTH_WORDS = 512,
  parameter int IW          = $clog2(DEPTH_WORDS)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rd_en,
  input  logic [IW-1:0]        rd_idx,
  output logic [TL_DATA_W-1:0] rd_data,
  input  logic                 wr_en,
  input  logic [IW-1:0]        wr_idx,
  input  logic [TL_MASK_W-1:0] wr_mask,
  input  logic [TL_DATA_W-1:0] wr_data
);

  logic [TL_DATA_W-1:0] mem_reg [DEPTH_WORDS];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int i = 0; i < TL_MASK_W; i++) begin
        if (wr_mask[i]) mem_reg[wr_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
      end
    end
  end

  // Holding the last read keeps D data stable while the sink stalls.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem_reg[rd_idx];
    end
  end

endmodule

// File: rtl/tl_sram_responder.sv
// TileLink-UL manager endpoint: one transaction in flight, multi-beat
// Get/Put bursts into a byte-maskable scratch memory, denial of bad requests.
module tl_sram_responder
  import tl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          DEPTH_WORDS = 512,
  parameter int          MAX_SIZE    = 6
) (
  input  logic                 clock,
  input  logic                 reset,
  output logic                 auto_in_a_ready,
  input  logic                 auto_in_a_valid,
  input  logic [2:0]           auto_in_a_bits_opcode,
  input  logic [2:0]           auto_in_a_bits_param,
  input  logic [2:0]           auto_in_a_bits_size,
  input  logic [TL_SRC_W-1:0]  auto_in_a_bits_source,
  input  logic [TL_ADDR_W-1:0] auto_in_a_bits_address,
  input  logic [TL_MASK_W-1:0] auto_in_a_bits_mask,
  input  logic [TL_DATA_W-1:0] auto_in_a_bits_data,
  input  logic                 auto_in_a_bits_corrupt,
  input  logic                 auto_in_d_ready,
  output logic                 auto_in_d_valid,
  output logic [2:0]           auto_in_d_bits_opcode,
  output logic [2:0]           auto_in_d_bits_size,
  output logic [TL_SRC_W-1:0]  auto_in_d_bits_source,
  output logic                 auto_in_d_bits_denied,
  output logic [TL_DATA_W-1:0] auto_in_d_bits_data,
  output logic                 auto_in_d_bits_corrupt
);

  localparam int          IW       = $clog2(DEPTH_WORDS);
  localparam logic [32:0] END_ADDR = 33'(BASE_ADDR) + 33'(8 * DEPTH_WORDS);

  tl_resp_state_e      state_reg, state_next;
  logic [4:0]          beat_reg, beat_next;
  logic [4:0]          beats_reg;
  logic [2:0]          size_reg;
  logic [TL_SRC_W-1:0] source_reg;
  logic                legal_reg;
  logic [IW-1:0]       word_reg;

  logic                 a_fire, d_fire, capture;
  logic                 a_legal, a_is_put, a_is_get;
  logic [TL_ADDR_W-1:0] a_offset;
  logic [IW-1:0]        a_word;
  logic [4:0]           a_beats;
  logic                 rd_en, wr_en;
  logic [IW-1:0]        rd_idx, wr_idx;
  logic [TL_DATA_W-1:0] rd_data;
  logic                 unused_ok;

  assign unused_ok = ^auto_in_a_bits_param;

  // Ready is gated by reset so no beat is accepted while it is held.
  assign auto_in_a_ready = reset && (state_reg == ST_IDLE || state_reg == ST_PUT_BURST);
  assign auto_in_d_valid = (state_reg == ST_ACK) || (state_reg == ST_GET_BURST);
  assign a_fire = auto_in_a_valid && auto_in_a_ready;
  assign d_fire = auto_in_d_valid && auto_in_d_ready;

  assign a_is_put = (auto_in_a_bits_opcode == TL_A_PUT_FULL) ||
                    (auto_in_a_bits_opcode == TL_A_PUT_PARTIAL);
  assign a_is_get = (auto_in_a_bits_opcode == TL_A_GET);
  assign a_legal  = (a_is_put || a_is_get) &&
                    (int'(auto_in_a_bits_size) <= MAX_SIZE) &&
                    (auto_in_a_bits_address >= BASE_ADDR) &&
                    ({1'b0, auto_in_a_bits_address} < END_ADDR);
  assign a_offset = auto_in_a_bits_address - BASE_ADDR;
  assign a_word   = IW'(a_offset >> 3);
  assign a_beats  = tl_beats(auto_in_a_bits_size);

  always_comb begin
    state_next = state_reg;
    beat_next  = beat_reg;
    capture    = 1'b0;
    rd_en      = 1'b0;
    rd_idx     = word_reg + IW'(beat_reg + 5'd1);
    wr_en      = 1'b0;
    wr_idx     = word_reg + IW'(beat_reg);
    case (state_reg)
      ST_IDLE: begin
        if (a_fire) begin
          capture   = 1'b1;
          beat_next = 5'd0;
          if (a_is_get) begin
            state_next = ST_GET_BURST;
            rd_en      = 1'b1;
            rd_idx     = a_word;
          end else if (a_is_put) begin
            wr_en  = a_legal && !auto_in_a_bits_corrupt;
            wr_idx = a_word;
            if (a_beats == 5'd1) begin
              state_next = ST_ACK;
            end else begin
              state_next = ST_PUT_BURST;
              beat_next  = 5'd1;
            end
          end else begin
            state_next = ST_ACK;
          end
        end
      end
      ST_PUT_BURST: begin
        if (a_fire) begin
          wr_en = legal_reg && !auto_in_a_bits_corrupt;
          if (beat_reg == beats_reg - 5'd1) begin
            state_next = ST_ACK;
            beat_next  = 5'd0;
          end else begin
            beat_next = beat_reg + 5'd1;
          end
        end
      end
      ST_ACK: begin
        if (d_fire) state_next = ST_IDLE;
      end
      ST_GET_BURST: begin
        if (d_fire) begin
          if (beat_reg == beats_reg - 5'd1) begin
            state_next = ST_IDLE;
            beat_next  = 5'd0;
          end else begin
            beat_next = beat_reg + 5'd1;
            rd_en     = 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg  <= ST_IDLE;
      beat_reg   <= '0;
      beats_reg  <= '0;
      size_reg   <= '0;
      source_reg <= '0;
      legal_reg  <= 1'b0;
      word_reg   <= '0;
    end else begin
      state_reg <= state_next;
      beat_reg  <= beat_next;
      if (capture) begin
        beats_reg  <= a_beats;
        size_reg   <= auto_in_a_bits_size;
        source_reg <= auto_in_a_bits_source;
        legal_reg  <= a_legal;
        word_reg   <= a_word;
      end
    end
  end

  tl_sram_responder_mem #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IW         (IW)
  ) u_mem (
    .clock  (clock),
    .reset  (reset),
    .rd_en  (rd_en),
    .rd_idx (rd_idx),
    .rd_data(rd_data),
    .wr_en  (wr_en),
    .wr_idx (wr_idx),
    .wr_mask(auto_in_a_bits_mask),
    .wr_data(auto_in_a_bits_data)
  );

  // D fields come only from registers; flags are qualified by valid so
  // the idle/reset bus reads all zeros.
  assign auto_in_d_bits_opcode  = (state_reg == ST_GET_BURST) ? TL_D_ACCESS_ACK_DATA
                                                              : TL_D_ACCESS_ACK;
  assign auto_in_d_bits_size    = size_reg;
  assign auto_in_d_bits_source  = source_reg;
  assign auto_in_d_bits_denied  = auto_in_d_valid && !legal_reg;
  assign auto_in_d_bits_corrupt = (state_reg == ST_GET_BURST) && !legal_reg;
  assign auto_in_d_bits_data    = (state_reg == ST_GET_BURST && legal_reg) ? rd_data : '0;

endmodule

// File: tb/tb_tl_sram_responder.sv
// Directed bench for tl_sram_responder: puts, partial puts, bursts,
// denied requests and asynchronous reset mid-burst.
module tb_tl_sram_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic        a_ready, a_valid, a_corrupt;
  logic [2:0]  a_opcode, a_param, a_size;
  logic [3:0]  a_source;
  logic [31:0] a_address;
  logic [7:0]  a_mask;
  logic [63:0] a_data;
  logic        d_ready, d_valid, d_denied, d_corrupt;
  logic [2:0]  d_opcode, d_size;
  logic [3:0]  d_source;
  logic [63:0] d_data;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  tl_sram_responder dut (
    .clock                 (clock),
    .reset                 (reset),
    .auto_in_a_ready       (a_ready),
    .auto_in_a_valid       (a_valid),
    .auto_in_a_bits_opcode (a_opcode),
    .auto_in_a_bits_param  (a_param),
    .auto_in_a_bits_size   (a_size),
    .auto_in_a_bits_source (a_source),
    .auto_in_a_bits_address(a_address),
    .auto_in_a_bits_mask   (a_mask),
    .auto_in_a_bits_data   (a_data),
    .auto_in_a_bits_corrupt(a_corrupt),
    .auto_in_d_ready       (d_ready),
    .auto_in_d_valid       (d_valid),
    .auto_in_d_bits_opcode (d_opcode),
    .auto_in_d_bits_size   (d_size),
    .auto_in_d_bits_source (d_source),
    .auto_in_d_bits_denied (d_denied),
    .auto_in_d_bits_data   (d_data),
    .auto_in_d_bits_corrupt(d_corrupt)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents one A beat, waits (bounded) for ready, and lets it fire.
  task automatic send_a(input string tag, input logic [2:0] op, input logic [2:0] sz,
                        input logic [3:0] src, input logic [31:0] addr,
                        input logic [7:0] mask, input logic [63:0] data,
                        input logic corrupt);
    a_valid = 1'b1; a_opcode = op; a_size = sz; a_source = src;
    a_address = addr; a_mask = mask; a_data = data; a_corrupt = corrupt;
    for (int i = 0; i < 20 && !a_ready; i++) tick();
    chk({tag, ".a_ready"}, 64'(a_ready), 64'd1);
    tick();
    a_valid = 1'b0;
    $display("A %s op=%0d size=%0d src=%0d addr=%h data=%h", tag, op, sz, src, addr, data);
  endtask

  // Accepts one D beat and checks its fields; data only for AccessAckData.
  task automatic recv_d(input string tag, input logic [2:0] op, input logic [2:0] sz,
                        input logic [3:0] src, input logic denied, input logic corrupt,
                        input logic [63:0] data);
    d_ready = 1'b1;
    for (int i = 0; i < 20 && !d_valid; i++) tick();
    chk({tag, ".d_valid"}, 64'(d_valid), 64'd1);
    chk({tag, ".opcode"},  64'(d_opcode), 64'(op));
    chk({tag, ".size"},    64'(d_size), 64'(sz));
    chk({tag, ".source"},  64'(d_source), 64'(src));
    chk({tag, ".denied"},  64'(d_denied), 64'(denied));
    chk({tag, ".corrupt"}, 64'(d_corrupt), 64'(corrupt));
    if (op == 3'd1) chk({tag, ".data"}, d_data, data);
    $display("D %s op=%0d src=%0d denied=%0d data=%h", tag, d_opcode, d_source, d_denied, d_data);
    tick();
    d_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; a_valid = 1'b0; a_opcode = '0; a_param = '0; a_size = '0;
    a_source = '0; a_address = '0; a_mask = '0; a_data = '0; a_corrupt = 1'b0;
    d_ready = 1'b0;
    repeat (3) tick();
    chk("rst.a_ready", 64'(a_ready), 64'd0);
    chk("rst.d_valid", 64'(d_valid), 64'd0);
    chk("rst.d_fields", {38'd0, d_opcode, d_size, d_source, d_denied, d_corrupt, 14'd0}, 64'd0);
    chk("rst.d_data", d_data, 64'd0);
    reset = 1'b1;
    tick();
    chk("idle.a_ready", 64'(a_ready), 64'd1);

    // Single-beat PutFull then Get of the same word
    send_a("put", 3'd0, 3'd3, 4'd5, 32'h1000_0008, 8'hFF, 64'hDEAD_BEEF_0123_4567, 1'b0);
    chk("put.ack_latency", 64'(d_valid), 64'd1);
    recv_d("put_ack", 3'd0, 3'd3, 4'd5, 1'b0, 1'b0, 64'd0);
    chk("put.b2b_a_ready", 64'(a_ready), 64'd1);
    send_a("get", 3'd4, 3'd3, 4'd2, 32'h1000_0008, 8'h00, 64'd0, 1'b0);
    chk("get.latency", 64'(d_valid), 64'd1);
    recv_d("get_data", 3'd1, 3'd3, 4'd2, 1'b0, 1'b0, 64'hDEAD_BEEF_0123_4567);

    // PutPartial over a known word
    send_a("put2", 3'd0, 3'd3, 4'd1, 32'h1000_0010, 8'hFF, 64'h1111_2222_3333_4444, 1'b0);
    recv_d("put2_ack", 3'd0, 3'd3, 4'd1, 1'b0, 1'b0, 64'd0);
    send_a("pput", 3'd1, 3'd3, 4'd3, 32'h1000_0010, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    recv_d("pput_ack", 3'd0, 3'd3, 4'd3, 1'b0, 1'b0, 64'd0);
    send_a("get2", 3'd4, 3'd3, 4'd4, 32'h1000_0010, 8'h00, 64'd0, 1'b0);
    recv_d("get2_data", 3'd1, 3'd3, 4'd4, 1'b0, 1'b0, 64'h1111_2222_FFFF_FFFF);

    // 64-byte PutFull burst: one ack only after the eighth beat
    for (int k = 0; k < 8; k++) begin
      send_a($sformatf("bput%0d", k), 3'd0, 3'd6, 4'd6, 32'h1000_0040, 8'hFF, 64'(k), 1'b0);
      if (k < 7) chk($sformatf("bput%0d.no_early_ack", k), 64'(d_valid), 64'd0);
    end
    chk("bput.ack_latency", 64'(d_valid), 64'd1);
    recv_d("bput_ack", 3'd0, 3'd6, 4'd6, 1'b0, 1'b0, 64'd0);

    // 64-byte Get burst with d_ready toggling
    send_a("bget", 3'd4, 3'd6, 4'd9, 32'h1000_0040, 8'h00, 64'd0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("bget%0d.valid", k), 64'(d_valid), 64'd1);
      chk($sformatf("bget%0d.data", k), d_data, 64'(k));
      d_ready = 1'b0;
      tick();
      chk($sformatf("bget%0d.hold", k), d_data, 64'(k));
      chk($sformatf("bget%0d.hold_src", k), 64'(d_source), 64'd9);
      d_ready = 1'b1;
      tick();
      $display("D bget%0d data=%h", k, 64'(k));
    end
    d_ready = 1'b0;
    chk("bget.done", 64'(d_valid), 64'd0);

    // Out-of-range Get: two denied, corrupt, zero-data beats
    send_a("oor_get", 3'd4, 3'd4, 4'd7, 32'h2000_0000, 8'h00, 64'd0, 1'b0);
    recv_d("oor0", 3'd1, 3'd4, 4'd7, 1'b1, 1'b1, 64'd0);
    recv_d("oor1", 3'd1, 3'd4, 4'd7, 1'b1, 1'b1, 64'd0);
    chk("oor.done", 64'(d_valid), 64'd0);

    // Unsupported opcode and corrupt PutFull
    send_a("arith", 3'd2, 3'd3, 4'd8, 32'h1000_0008, 8'hFF, 64'd0, 1'b0);
    recv_d("arith_ack", 3'd0, 3'd3, 4'd8, 1'b1, 1'b0, 64'd0);
    send_a("cput", 3'd0, 3'd3, 4'd10, 32'h1000_0008, 8'hFF, 64'h0BAD_0BAD_0BAD_0BAD, 1'b1);
    recv_d("cput_ack", 3'd0, 3'd3, 4'd10, 1'b0, 1'b0, 64'd0);
    send_a("get3", 3'd4, 3'd3, 4'd11, 32'h1000_0008, 8'h00, 64'd0, 1'b0);
    recv_d("get3_data", 3'd1, 3'd3, 4'd11, 1'b0, 1'b0, 64'hDEAD_BEEF_0123_4567);

    // Async reset while beat 3 of an 8-beat Get is on the bus
    send_a("rget", 3'd4, 3'd6, 4'd12, 32'h1000_0040, 8'h00, 64'd0, 1'b0);
    d_ready = 1'b1;
    repeat (3) tick();
    chk("rget3.data", d_data, 64'd3);
    d_ready = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst.d_valid", 64'(d_valid), 64'd0);
    chk("async_rst.a_ready", 64'(a_ready), 64'd0);
    $display("R async reset asserted mid-burst");
    repeat (2) tick();
    reset = 1'b1;
    tick();
    chk("post_rst.a_ready", 64'(a_ready), 64'd1);
    chk("post_rst.d_valid", 64'(d_valid), 64'd0);
    send_a("get4", 3'd4, 3'd3, 4'd13, 32'h1000_0048, 8'h00, 64'd0, 1'b0);
    recv_d("get4_data", 3'd1, 3'd3, 4'd13, 1'b0, 1'b0, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tl_sram_responder.md
Name: tl_sram_responder

Overview:
- TileLink-UL manager (responder) endpoint.
- Accepts A-channel requests arriving through the monitor/passthrough node chain and answers on the D channel.
- Backs a small byte-maskable scratch memory; one transaction in flight.
- Supports multi-beat Get and Put bursts. Unsupported or out-of-range requests get denied responses.

Parameters:
- BASE_ADDR, 32'h1000_0000: first byte address served.
- DEPTH_WORDS, 512: number of 64-bit words; power of two.
- MAX_SIZE, 6: largest legal log2 transfer size (64 B = 8 beats).

Ports:
- clock  in  1  sole clock
- reset  in  1  asynchronous, active-low reset
- auto_in_a_ready  out  1  A channel ready
- auto_in_a_valid  in  1  A channel valid
- auto_in_a_bits_opcode  in  3  request opcode
- auto_in_a_bits_param  in  3  ignored
- auto_in_a_bits_size  in  3  log2 bytes
- auto_in_a_bits_source  in  4  request ID
- auto_in_a_bits_address  in  32  byte address, size-aligned
- auto_in_a_bits_mask  in  8  byte lanes
- auto_in_a_bits_data  in  64  write data
- auto_in_a_bits_corrupt  in  1  beat corrupt
- auto_in_d_ready  in  1  D channel ready
- auto_in_d_valid  out  1  D channel valid
- auto_in_d_bits_opcode  out  3  0 = AccessAck, 1 = AccessAckData
- auto_in_d_bits_size  out  3  echo of request size
- auto_in_d_bits_source  out  4  echo of request source
- auto_in_d_bits_denied  out  1  request refused
- auto_in_d_bits_data  out  64  read data
- auto_in_d_bits_corrupt  out  1  data invalid

Behaviour:
- Reset (reset = 0, async):
  - state = IDLE; d_valid = 0; a_ready = 0 while reset is asserted; beat counter = 0.
  - D bit fields and captured request fields reset to 0. Memory contents are not reset.
  - Reset mid-burst abandons the transaction with no response.
- Beats per transfer: beats = (size <= 3) ? 1 : 2^(size-3).
- Legality:
  - legal = opcode in {0 PutFull, 1 PutPartial, 4 Get} and size <= MAX_SIZE and BASE_ADDR <= addr < BASE_ADDR + 8*DEPTH_WORDS.
  - Word index = ((addr - BASE_ADDR) >> 3) + beat; aligned addressing means no wrap inside a burst.
- FSM states:
  - IDLE:
    - a_ready = 1.
    - On the first A fire, capture opcode, size, source and legal.
    - Get → GET_BURST. Put with beats = 1 → ACK. Put with beats > 1 → PUT_BURST. Any other opcode → ACK with denied.
  - PUT_BURST:
    - a_ready = 1; each fire increments beat.
    - On the fire where beat == beats-1 → ACK.
    - Later-beat header fields are ignored; captured values are used.
  - ACK:
    - a_ready = 0; d_valid = 1, opcode 0, denied = !legal, corrupt = 0.
    - On d fire → IDLE.
  - GET_BURST:
    - a_ready = 0; d_valid = 1, opcode 1.
    - Data = mem[index]; denied = !legal; corrupt = !legal; data = 0 when denied.
    - On each d fire beat++. On the fire of the last beat → IDLE with beat cleared.
- Writes:
  - Performed on the A fire cycle, byte-masked by a_mask, only if legal and a_corrupt = 0.
  - Illegal or corrupt beats are consumed silently.
- Latency:
  - Get accepted in cycle T → beat 0 valid at T+1 (synchronous read registered on fire).
  - Beat i+1 valid the cycle after beat i fires; sustained 1 beat/cycle when d_ready stays high.
  - Final Put beat at T → AccessAck valid at T+1.
- D stability: d_valid and all D fields hold stable until d_ready; no combinational path from d_ready to d_valid.
- Back-to-back: a_ready rises the cycle after the final D fire; no A/D overlap.
- Get ignores a_mask and a_data; full words are returned.

Decomposition:
- Shared package tl_pkg holds:
  - TL opcode constants for A and D channels.
  - Field widths (source 4, address 32, data 64).
  - Beat-count function.
- One sub-module, tl_sram_responder_mem:
  - DEPTH_WORDS x 64 flop array.
  - Synchronous read port; byte-masked write port.

Test Plan:
- Put: PutFull size 3, addr 0x1000_0008, data 0xDEAD_BEEF_0123_4567, src 5.
  - Response: one AccessAck, src 5, denied 0, d_valid the cycle after the fire.
  - Then Get of the same address → AccessAckData with the same data.
- PutPartial: PutPartial mask 0x0F, data 0xFFFF_FFFF_FFFF_FFFF over word 0x1111_2222_3333_4444 → later Get returns 0x1111_2222_FFFF_FFFF.
- 64 B burst: PutFull size 6 at 0x1000_0040, 8 beats of data k.
  - a_ready high for all 8 beats; a single AccessAck follows.
  - Get size 6 returns beats 0..7 in order; d_ready toggled 1/0 shows stable holds.
- Out-of-range Get: Get at 0x2000_0000, size 4 → 2 beats, denied = 1, corrupt = 1, data 0; memory unchanged.
- Unsupported opcode: opcode 2 (Arithmetic) → single AccessAck with denied = 1.
  - Corrupt-flagged PutFull → AccessAck denied 0, memory unchanged.
- Async reset: assert reset during beat 3 of an 8-beat Get → d_valid drops immediately.
  - After release, a_ready = 1 in IDLE and a new Get completes normally.
